// File: rtl/tff_counter_ctrl_pkg.sv
// Shared definitions for the T flip-flop counter controller.
// Provides the FSM state encoding, count-direction constants and the
// default counter width used by the interface and the top module.
package tff_ctrl_pkg;

  // Default counter / register width in bits
  localparam int DEF_W = 4;

  // Count direction as seen on the dir input
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    DONE = 2'b11
  } state_t;

endpackage

// File: rtl/tff_counter_ctrl_if.sv
// Control/status bundle between a sequencing master and tff_counter_ctrl.
// master drives start/stop/dir/one_shot/limit/load_en/load_val and observes
// q/busy/done/tc; slave (the controller) is the mirror image.
interface tff_counter_ctrl_if #(
  parameter int W = tff_ctrl_pkg::DEF_W
);
  import tff_ctrl_pkg::*;

  logic         start;
  logic         stop;
  logic         dir;
  logic         one_shot;
  logic [W-1:0] limit;
  logic         load_en;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic         busy;
  logic         done;
  logic         tc;

  modport master (
    output start, stop, dir, one_shot, limit, load_en, load_val,
    input  q, busy, done, tc
  );

  modport slave (
    input  start, stop, dir, one_shot, limit, load_en, load_val,
    output q, busy, done, tc
  );

endinterface

// File: rtl/tff_counter_ctrl_cell.sv
// Single T flip-flop cell of the counter register.
// Ports: clk (falling-edge clock), clr (async active-low clear),
// t (toggle enable), q (stored bit). q_next = q ^ t.
module tff_cell (
  input  logic clk,
  input  logic clr,
  input  logic t,
  output logic q
);

  always_ff @(negedge clk or negedge clr) begin
    if (!clr) begin
      q <= 1'b0;
    end else begin
      q <= q ^ t;
    end
  end

endmodule

// File: rtl/tff_counter_ctrl.sv
// Sequencing controller driving a W-bit register of T flip-flop cells as a
// modulo up/down counter with load, run/hold/stop and one-shot/continuous mode.
// Ports: clk (falling-edge clock), clr (async active-low reset), bus (slave
// modport: control inputs in, q/busy/done/tc out).
module tff_counter_ctrl #(
  parameter int W = tff_ctrl_pkg::DEF_W
) (
  input  logic               clk,
  input  logic               clr,
  tff_counter_ctrl_if.slave  bus
);
  import tff_ctrl_pkg::*;

  state_t       state;
  logic         tc_q;
  logic [W-1:0] q;
  logic [W-1:0] t;
  logic [W-1:0] up_t;
  logic [W-1:0] dn_t;
  logic [W-1:0] lo_mask;
  logic [W-1:0] restart_val;
  logic         at_term;

  // The register itself: one T cell per bit, toggled by t
  for (genvar i = 0; i < W; i++) begin : g_cell
    tff_cell u_cell (
      .clk (clk),
      .clr (clr),
      .t   (t[i]),
      .q   (q[i])
    );
  end

  // Terminal value: limit when counting up, zero when counting down
  assign at_term     = (bus.dir == DIR_UP) ? (q == bus.limit) : (q == '0);
  assign restart_val = (bus.dir == DIR_UP) ? '0 : bus.limit;

  // Ripple toggle terms: bit i toggles when every lower bit is 1 (up)
  // or every lower bit is 0 (down). Bit 0 always toggles.
  always_comb begin
    up_t    = '0;
    dn_t    = '0;
    lo_mask = '0;
    for (int i = 0; i < W; i++) begin
      lo_mask = W'((1 << i) - 1);
      up_t[i] = &(q | ~lo_mask);
      dn_t[i] = &(~q | ~lo_mask);
    end
  end

  // Toggle vector. Loads and restarts are expressed as q ^ target so the
  // T cells land on the target value in one edge.
  always_comb begin
    t = '0;
    case (state)
      IDLE, HOLD: begin
        if (!bus.stop && !bus.start && bus.load_en) begin
          t = q ^ bus.load_val;
        end
      end
      RUN: begin
        if (!bus.stop) begin
          if (!at_term) begin
            t = (bus.dir == DIR_UP) ? up_t : dn_t;
          end else if (!bus.one_shot) begin
            // Wrap: up lands on 0, down lands on limit (q is 0 here)
            t = q ^ restart_val;
          end
        end
      end
      DONE: begin
        if (bus.start && !bus.stop) begin
          t = q ^ restart_val;
        end else if (bus.load_en) begin
          t = q ^ bus.load_val;
        end
      end
      default: t = '0;
    endcase
  end

  // FSM and registered terminal-count pulse
  always_ff @(negedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      tc_q  <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      case (state)
        IDLE, HOLD: begin
          if (!bus.stop && bus.start) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state <= HOLD;
          end else if (at_term) begin
            tc_q <= 1'b1;
            if (bus.one_shot) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.start && !bus.stop) begin
            state <= RUN;
          end else if (bus.load_en) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.q    = q;
  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.tc   = tc_q;

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// Self-checking bench for tff_counter_ctrl (W=4). Expected q/busy/done/tc
// per active edge are queued as stimulus is set up, then popped and compared
// on the following rising edge, away from the falling active edge.
module tb_tff_counter_ctrl;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] q;
    logic         busy;
    logic         done;
    logic         tc;
  } exp_t;

  logic clk;
  logic clr;
  exp_t sb[$];
  int   n_chk;
  int   n_err;
  int   n_cyc;

  tff_counter_ctrl_if #(.W(W)) bus ();

  tff_counter_ctrl #(.W(W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t cyc %0d: got %0h expected %0h", tag, $time, n_cyc, act, exp);
    end
  endtask

  task automatic push(input int q, input logic b, input logic d, input logic t);
    exp_t e;
    e.q    = q[W-1:0];
    e.busy = b;
    e.done = d;
    e.tc   = t;
    sb.push_back(e);
  endtask

  // One active edge per queued entry, compared on the following rising edge
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      @(negedge clk);
      @(posedge clk);
      n_cyc++;
      e = sb.pop_front();
      check("q",    32'(bus.q),    32'(e.q));
      check("busy", 32'(bus.busy), 32'(e.busy));
      check("done", 32'(bus.done), 32'(e.done));
      check("tc",   32'(bus.tc),   32'(e.tc));
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    n_cyc = 0;
    clr          = 1'b0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.dir      = 1'b0;
    bus.one_shot = 1'b0;
    bus.limit    = 4'd9;
    bus.load_en  = 1'b0;
    bus.load_val = '0;

    #2;
    check("rst_q",    32'(bus.q),    0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_tc",   32'(bus.tc),   0);
    @(posedge clk);
    clr = 1'b1;

    // Continuous up, limit 9: 0,1..9,0(tc),1
    bus.start = 1'b1;
    push(0, 1, 0, 0);
    drain();
    bus.start = 1'b0;
    for (int k = 1; k <= 9; k++) push(k, 1, 0, 0);
    push(0, 1, 0, 1);
    push(1, 1, 0, 0);
    drain();

    // Asynchronous reset mid-cycle while counting
    #2 clr = 1'b0;
    #1;
    check("arst_q",    32'(bus.q),    0);
    check("arst_busy", 32'(bus.busy), 0);
    check("arst_done", 32'(bus.done), 0);
    check("arst_tc",   32'(bus.tc),   0);
    #1 clr = 1'b1;

    // start together with stop in IDLE: stop wins
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    push(0, 0, 0, 0);
    drain();
    bus.start = 1'b0;
    bus.stop  = 1'b0;

    // One-shot down from a loaded 5
    bus.load_en  = 1'b1;
    bus.load_val = 4'd5;
    push(5, 0, 0, 0);
    drain();
    bus.load_en  = 1'b0;
    bus.dir      = 1'b1;
    bus.one_shot = 1'b1;
    bus.start    = 1'b1;
    push(5, 1, 0, 0);
    drain();
    bus.start = 1'b0;
    for (int k = 4; k >= 0; k--) push(k, 1, 0, 0);
    push(0, 0, 1, 1);
    push(0, 0, 1, 0);
    drain();
    // Restart from DONE counting down: q jumps to limit, no tc
    bus.start = 1'b1;
    push(9, 1, 0, 0);
    drain();
    bus.start = 1'b0;
    push(8, 1, 0, 0);
    drain();
    bus.stop = 1'b1;
    push(8, 0, 0, 0);
    drain();
    bus.stop = 1'b0;

    // Hold/resume: load 0 in HOLD, count up to 3, pause, resume
    bus.load_en  = 1'b1;
    bus.load_val = 4'd0;
    push(0, 0, 0, 0);
    drain();
    bus.load_en  = 1'b0;
    bus.dir      = 1'b0;
    bus.one_shot = 1'b0;
    bus.start    = 1'b1;
    push(0, 1, 0, 0);
    drain();
    bus.start = 1'b0;
    for (int k = 1; k <= 3; k++) push(k, 1, 0, 0);
    drain();
    bus.stop = 1'b1;
    push(3, 0, 0, 0);
    drain();
    bus.stop  = 1'b0;
    bus.start = 1'b1;
    push(3, 1, 0, 0);
    drain();
    bus.start = 1'b0;
    push(4, 1, 0, 0);
    drain();

    // load_en ignored in RUN
    bus.load_en  = 1'b1;
    bus.load_val = 4'hA;
    push(5, 1, 0, 0);
    drain();
    bus.load_en = 1'b0;
    for (int k = 6; k <= 9; k++) push(k, 1, 0, 0);
    drain();
    // stop at q == limit: hold, no wrap, no tc
    bus.stop = 1'b1;
    push(9, 0, 0, 0);
    drain();
    bus.stop = 1'b0;

    // Out of range: load 12 with limit 9, counts through 15 -> 0 without tc
    bus.load_en  = 1'b1;
    bus.load_val = 4'd12;
    push(12, 0, 0, 0);
    drain();
    bus.load_en = 1'b0;
    bus.start   = 1'b1;
    push(12, 1, 0, 0);
    drain();
    bus.start = 1'b0;
    for (int k = 13; k <= 15; k++) push(k, 1, 0, 0);
    for (int k = 0; k <= 9; k++) push(k, 1, 0, 0);
    push(0, 1, 0, 1);
    push(1, 1, 0, 0);
    drain();

    // Mid-run switch to down with limit 0: terminal every cycle once at 0
    bus.dir   = 1'b1;
    bus.limit = 4'd0;
    push(0, 1, 0, 0);
    for (int k = 0; k < 3; k++) push(0, 1, 0, 1);
    drain();

    // One-shot up to limit 2, then load from DONE returns to IDLE
    bus.dir      = 1'b0;
    bus.limit    = 4'd2;
    bus.one_shot = 1'b1;
    push(1, 1, 0, 0);
    push(2, 1, 0, 0);
    push(2, 0, 1, 1);
    drain();
    bus.load_en  = 1'b1;
    bus.load_val = 4'd7;
    push(7, 0, 0, 0);
    drain();
    bus.load_en = 1'b0;
    bus.start   = 1'b1;
    bus.stop    = 1'b1;
    push(7, 0, 0, 0);
    push(7, 0, 0, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tff_counter_ctrl.md
Name: tff_counter_ctrl

Overview:
- Sequencing controller for a W-bit register built from T flip-flop cells.
- Each cycle it computes the per-bit toggle vector t[W-1:0] that makes the register count up or down modulo a programmable limit.
- Also supports load, run/hold/stop control and one-shot or continuous mode.
- Sits beside the toggle-flop register array as its sole driver; the register contents are the counter value q.

Parameters:
- W, 4, counter/register width in bits (W >= 2).

Ports:
- clk  input  1  clock; all state updates on the falling edge of clk.
- clr  input  1  asynchronous, active-low reset.
- start  input  1  begin or resume counting.
- stop  input  1  pause counting.
- dir  input  1  0 = up, 1 = down; sampled every edge.
- one_shot  input  1  1 = halt at terminal value, 0 = wrap continuously.
- limit  input  W  modulo limit; sampled every edge.
- load_en  input  1  load load_val into q (not in RUN).
- load_val  input  W  value to load.
- q  output  W  counter value (T-cell outputs).
- busy  output  1  high while in RUN.
- done  output  1  high while in DONE.
- tc  output  1  one-cycle registered terminal-count pulse.

Behaviour:
- Reset (clr=0, async): q=0, state=IDLE, busy=0, done=0, tc=0, t=0.
- Register update: every falling edge, q_next = q ^ t. Outside RUN, t=0 except for load or restart.
- State encoding: IDLE, RUN, HOLD, DONE.
- IDLE / HOLD:
  - stop=1 → stay.
  - else start=1 → RUN.
  - else load_en=1 → t = q ^ load_val, stay.
  - start takes priority over load_en.
- RUN:
  - stop=1 → HOLD; q unchanged on that edge.
  - Terminal value is limit when dir=0, 0 when dir=1.
  - Not at terminal, up: t[0]=1, t[i]=&q[i-1:0].
  - Not at terminal, down: t[0]=1, t[i]=&(~q[i-1:0]).
  - At terminal: tc=1 on the next edge.
    - one_shot=1 → DONE, t=0, q holds the terminal value.
    - one_shot=0, up → wrap: t=q, so q becomes 0.
    - one_shot=0, down → wrap: t=limit, so q becomes limit.
  - load_en is ignored in RUN.
- DONE:
  - start=1 (and stop=0) → RUN. On the same edge q is set to 0 (up) or limit (down), with no tc.
  - load_en=1 → load as in IDLE, go to IDLE.
- Latency:
  - start sampled at edge k → busy=1 after edge k; first count applied at edge k+1.
  - stop sampled at edge k → busy=0 after edge k, no count at edge k.
- Simultaneous events:
  - start with stop: stop wins.
  - Terminal reached with stop in the same cycle: stop wins, no wrap, no tc.
- Out-of-range values:
  - Up with q > limit: counts naturally through 2^W-1 → 0; no tc at that rollover.
  - Down with limit=0: terminal every cycle, so q stays 0 and tc fires each cycle in continuous mode.
- Mid-run changes:
  - dir change in RUN takes effect on the next edge.
  - limit change in RUN is compared on the next edge.
- Reset mid-operation: immediate return to reset values regardless of edge.
- busy = (state==RUN); done = (state==DONE); both are decoded from registered state.

Decomposition:
- Package tff_ctrl_pkg:
  - State encoding constants: IDLE=2'b00, RUN=2'b01, HOLD=2'b10, DONE=2'b11.
  - DIR_UP=0, DIR_DN=1.
  - Default width constant W=4.
- Sub-module tff_cell:
  - Single T flip-flop: falling-edge clk, async active-low clr, q_next = q ^ t.
  - Instantiated W times by tff_counter_ctrl.
- Toggle-vector logic and FSM stay in the top module.

Test Plan:
- Reset: W=4, drive clr=0 mid-cycle → q=0, busy=0, done=0 and tc=0 immediately, before any clock edge.
- Continuous up: limit=9, dir=0, one_shot=0, start pulse → q reads 0,1,…,9,0,1; tc=1 for exactly the one cycle after 9→0.
- One-shot down:
  - load_val=5 with load_en in IDLE → q=5.
  - Then start with dir=1, one_shot=1 → q reads 4,3,2,1,0.
  - tc pulses once, done=1, busy=0, q holds 0.
  - Then start → q=limit, RUN.
- Hold/resume: up-count to q=3, stop=1 one cycle → q stays 3 in HOLD; start → q=4 on the second edge after start.
- Simultaneous inputs:
  - start=stop=1 in IDLE → remains IDLE.
  - load_en in RUN → ignored, count continues.
  - stop asserted at q=limit → HOLD, no wrap, no tc.
- Out-of-range: load_val=12, limit=9, up, continuous → q reads 13,14,15,0 with no tc, then counts to 9 and wraps with tc.
